// File: rtl/router_register_param.sv
// Router register slice: header/hold capture, output byte staging, running
// XOR-parity or additive checksum, payload length check and packet error flags.
module router_register_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LEN_W    = 6,
  parameter int unsigned CHK_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              rst_int_reg,
  input  logic              detect_addr,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              lfd_state,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              len_err,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] chk_q, chk_d;
  logic [DATA_W-1:0] pchk_q, pchk_d;
  logic [LEN_W:0]    cnt_q, cnt_d;
  logic              pd_q, pd_d, pd_dly_q;
  logic              lpv_q, lpv_d;
  logic              err_q, err_d;
  logic              lerr_q, lerr_d;

  logic              payload_fold;
  logic              capture;
  logic              pd_rise;
  logic [LEN_W-1:0]  hdr_len;

  function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    if (CHK_MODE == 0) return a ^ b;
    else               return a + b;
  endfunction

  always_comb begin
    payload_fold = ld_state && pkt_valid && !full_state;
    capture      = (ld_state && !fifo_full && !pkt_valid) ||
                   (laf_state && lpv_q && !pd_q);
    // err/len_err are evaluated once, the cycle after parity_done first rises
    pd_rise      = pd_q && !pd_dly_q;
    hdr_len      = hdr_q[DATA_W-1 -: LEN_W];

    hdr_d = hdr_q;
    if (detect_addr && pkt_valid && (data_in[1:0] != 2'b11)) hdr_d = data_in;

    hold_d = hold_q;
    if (!lfd_state && ld_state && fifo_full) hold_d = data_in;

    dout_d = dout_q;
    if (lfd_state)                   dout_d = hdr_q;
    else if (ld_state && !fifo_full) dout_d = data_in;
    else if (laf_state)              dout_d = hold_q;

    chk_d = chk_q;
    if (detect_addr)       chk_d = '0;
    else if (lfd_state)    chk_d = fold(chk_q, hdr_q);
    else if (payload_fold) chk_d = fold(chk_q, data_in);

    cnt_d = cnt_q;
    if (detect_addr)                       cnt_d = '0;
    else if (payload_fold && cnt_q != '1)  cnt_d = cnt_q + (LEN_W+1)'(1);

    pchk_d = pchk_q;
    if (capture) pchk_d = data_in;

    pd_d = pd_q;
    if (detect_addr)  pd_d = 1'b0;
    else if (capture) pd_d = 1'b1;

    lpv_d = lpv_q;
    if (rst_int_reg)                 lpv_d = 1'b0;
    else if (ld_state && !pkt_valid) lpv_d = 1'b1;

    err_d = err_q;
    if (detect_addr)                     err_d = 1'b0;
    else if (pd_rise && pchk_q != chk_q) err_d = 1'b1;

    lerr_d = lerr_q;
    if (detect_addr)                                 lerr_d = 1'b0;
    else if (pd_rise && cnt_q != {1'b0, hdr_len})    lerr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_q    <= '0;
      hold_q   <= '0;
      dout_q   <= '0;
      chk_q    <= '0;
      pchk_q   <= '0;
      cnt_q    <= '0;
      pd_q     <= 1'b0;
      pd_dly_q <= 1'b0;
      lpv_q    <= 1'b0;
      err_q    <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      hdr_q    <= hdr_d;
      hold_q   <= hold_d;
      dout_q   <= dout_d;
      chk_q    <= chk_d;
      pchk_q   <= pchk_d;
      cnt_q    <= cnt_d;
      pd_q     <= pd_d;
      pd_dly_q <= pd_q;
      lpv_q    <= lpv_d;
      err_q    <= err_d;
      lerr_q   <= lerr_d;
    end
  end

  assign data_out      = dout_q;
  assign parity_done   = pd_q;
  assign low_pkt_valid = lpv_q;
  assign err           = err_q;
  assign len_err       = lerr_q;

endmodule

// File: tb/tb_router_register_param.sv
// Directed bench for router_register_param: XOR-mode and additive-mode instances
// share stimulus; each scenario task checks its own expected values.
module tb_router_register_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid, fifo_full, rst_int_reg, detect_addr;
  logic       ld_state, laf_state, full_state, lfd_state;
  logic [7:0] data_in;

  logic       pd0, lpv0, err0, lerr0;
  logic [7:0] dout0;
  logic       pd1, lpv1, err1, lerr1;
  logic [7:0] dout1;

  int errors = 0;
  int checks = 0;

  logic [7:0] pl [5];

  always #5 clk = ~clk;

  router_register_param #(.DATA_W(8), .LEN_W(6), .CHK_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_addr(detect_addr),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .lfd_state(lfd_state), .parity_done(pd0), .low_pkt_valid(lpv0),
    .err(err0), .len_err(lerr0), .data_out(dout0)
  );

  router_register_param #(.DATA_W(8), .LEN_W(6), .CHK_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_addr(detect_addr),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .lfd_state(lfd_state), .parity_done(pd1), .low_pkt_valid(lpv1),
    .err(err1), .len_err(lerr1), .data_out(dout1)
  );

  // One clock with the given controls; returns 1 time unit after the edge.
  task automatic step(input logic dv, input logic lf, input logic ld,
                      input logic la, input logic fs, input logic ff,
                      input logic pv, input logic ri, input logic [7:0] din);
    detect_addr = dv; lfd_state = lf; ld_state = ld; laf_state = la;
    full_state = fs; fifo_full = ff; pkt_valid = pv; rst_int_reg = ri;
    data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout0); end
    checks++; if ({pd0, lpv0, err0, lerr0} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {pd0, lpv0, err0, lerr0}); end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_good_packet();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44; pl[4] = 8'h55;
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h16);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h11);
    checks++; if (dout0 !== 8'h16) begin errors++; $display("FAIL good_hdr_out: got %h want 16", dout0); end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 0, 0, 1, 0, pl[i]);
      checks++; if (dout0 !== pl[i]) begin errors++; $display("FAIL good_payload%0d: got %h want %h", i, dout0, pl[i]); end
    end
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h07);
    checks++; if ({pd0, err0} !== 2'b10) begin errors++; $display("FAIL good_capture pd/err: got %b want 10", {pd0, err0}); end
    idle();
    checks++; if ({pd0, lpv0, err0, lerr0} !== 4'b1100) begin errors++; $display("FAIL good_eval pd/lpv/err/len: got %b want 1100", {pd0, lpv0, err0, lerr0}); end
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    checks++; if (lpv0 !== 1'b0) begin errors++; $display("FAIL good_lpv_clear: got %b want 0", lpv0); end
  endtask

  task automatic test_bad_check();
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h16);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h11);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 1, 0, pl[i]);
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h2E);
    checks++; if ({pd0, err0} !== 2'b10) begin errors++; $display("FAIL bad_capture pd/err: got %b want 10", {pd0, err0}); end
    idle();
    checks++; if ({err0, lerr0} !== 2'b10) begin errors++; $display("FAIL bad_err_rise err/len: got %b want 10", {err0, lerr0}); end
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    idle();
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL bad_err_sticky: got %b want 1", err0); end
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h16);
    checks++; if ({pd0, err0} !== 2'b00) begin errors++; $display("FAIL bad_err_clear pd/err: got %b want 00", {pd0, err0}); end
  endtask

  task automatic test_fifo_full();
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h16);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h11);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h11);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h22);
    step(0, 0, 1, 0, 0, 1, 1, 0, 8'h33);
    checks++; if (dout0 !== 8'h22) begin errors++; $display("FAIL full_hold_out: got %h want 22", dout0); end
    // stalled cycle re-presents the same byte; it must not be counted or folded again
    step(0, 0, 1, 0, 1, 1, 1, 0, 8'h33);
    checks++; if (dout0 !== 8'h22) begin errors++; $display("FAIL full_stall_out: got %h want 22", dout0); end
    step(0, 0, 0, 1, 0, 0, 1, 0, 8'h44);
    checks++; if (dout0 !== 8'h33) begin errors++; $display("FAIL laf_out: got %h want 33", dout0); end
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h44);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h55);
    checks++; if (dout0 !== 8'h55) begin errors++; $display("FAIL full_last_payload: got %h want 55", dout0); end
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h07);
    idle();
    checks++; if ({pd0, err0, lerr0} !== 3'b100) begin errors++; $display("FAIL full_eval pd/err/len: got %b want 100", {pd0, err0, lerr0}); end
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
  endtask

  task automatic test_len_err();
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h16);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h11);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 1, 0, pl[i]);
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h52);
    idle();
    checks++; if ({pd0, err0, lerr0} !== 3'b101) begin errors++; $display("FAIL len_eval pd/err/len: got %b want 101", {pd0, err0, lerr0}); end
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    idle();
    checks++; if (lerr0 !== 1'b1) begin errors++; $display("FAIL len_sticky: got %b want 1", lerr0); end
  endtask

  task automatic test_addr3();
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h1B);
    checks++; if (lerr0 !== 1'b0) begin errors++; $display("FAIL addr3_len_clear: got %b want 0", lerr0); end
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
    checks++; if (dout0 !== 8'h16) begin errors++; $display("FAIL addr3_hdr_kept: got %h want 16", dout0); end
  endtask

  task automatic test_laf_capture();
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 0, 1, 0, 0, 8'hA5);
    checks++; if ({lpv0, pd0} !== 2'b10) begin errors++; $display("FAIL laf_lpv_set lpv/pd: got %b want 10", {lpv0, pd0}); end
    step(0, 0, 0, 1, 0, 0, 0, 0, 8'h5C);
    checks++; if ({pd0, dout0} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL laf_capture pd/dout: got %b/%h want 1/a5", pd0, dout0); end
    idle();
    checks++; if ({err0, lerr0} !== 2'b10) begin errors++; $display("FAIL laf_eval err/len: got %b want 10", {err0, lerr0}); end
    step(0, 0, 1, 0, 0, 1, 0, 1, 8'h00);
    checks++; if (lpv0 !== 1'b0) begin errors++; $display("FAIL lpv_rst_wins: got %b want 0", lpv0); end
  endtask

  task automatic test_chk_mode1();
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h0E);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'hFF);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'hFF);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h02);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h10);
    checks++; if (dout1 !== 8'h10) begin errors++; $display("FAIL m1_payload_out: got %h want 10", dout1); end
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h1F);
    idle();
    checks++; if ({pd1, err1, lerr1} !== 3'b100) begin errors++; $display("FAIL m1_good pd/err/len: got %b want 100", {pd1, err1, lerr1}); end
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h0E);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'hFF);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'hFF);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h02);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h10);
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h20);
    idle();
    checks++; if ({pd1, err1, lerr1} !== 3'b110) begin errors++; $display("FAIL m1_bad pd/err/len: got %b want 110", {pd1, err1, lerr1}); end
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
  endtask

  task automatic test_reset_mid_packet();
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h16);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h11);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h11);
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h22);
    checks++; if ({dout0, lpv0, pd0} !== {8'h22, 1'b1, 1'b1}) begin errors++; $display("FAIL pre_reset dout/lpv/pd: got %h/%b/%b want 22/1/1", dout0, lpv0, pd0); end
    #2 reset = 1'b1;
    #1;
    checks++; if (dout0 !== 8'h00 || dout1 !== 8'h00) begin errors++; $display("FAIL async_reset_dout: got %h/%h want 00/00", dout0, dout1); end
    checks++; if ({pd0, lpv0, err0, lerr0} !== 4'b0000) begin errors++; $display("FAIL async_reset_flags: got %b want 0000", {pd0, lpv0, err0, lerr0}); end
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h16);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h11);
    checks++; if (dout0 !== 8'h16) begin errors++; $display("FAIL post_reset_hdr: got %h want 16", dout0); end
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 1, 0, pl[i]);
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h07);
    idle();
    checks++; if ({pd0, err0, lerr0} !== 3'b100) begin errors++; $display("FAIL post_reset_eval pd/err/len: got %b want 100", {pd0, err0, lerr0}); end
  endtask

  initial begin
    reset = 1'b1;
    detect_addr = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; fifo_full = 0; pkt_valid = 0; rst_int_reg = 0;
    data_in = 8'h00;
    test_reset();
    test_good_packet();
    test_bad_check();
    test_fifo_full();
    test_len_err();
    test_addr3();
    test_laf_capture();
    test_chk_mode1();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_register_param.md
ROUTER_REGISTER_PARAM -- requirements
Module: router_register_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 8: byte width of data_in, data_out and check byte (legal range 8..32).
REQ-002 SHALL provide parameter LEN_W, default 6: width of the header length field header[DATA_W-1:DATA_W-LEN_W]; LEN_W <= DATA_W-2.
REQ-003 SHALL provide parameter CHK_MODE, default 0: 0 = XOR parity, 1 = additive checksum mod 2^DATA_W.
REQ-004 SHALL provide ports, one per line:
 clk  in  1  single clock; all state updates on the rising edge
 reset  in  1  asynchronous, active-high reset
 pkt_valid  in  1  packet body in progress on data_in
 data_in  in  DATA_W  header/payload/check byte
 fifo_full  in  1  destination FIFO full
 rst_int_reg  in  1  clears low_pkt_valid
 detect_addr  in  1  FSM in header-detect state
 ld_state  in  1  FSM loading payload
 laf_state  in  1  FSM loading after full
 full_state  in  1  FSM stalled on full FIFO
 lfd_state  in  1  FSM loading first (header) byte
 parity_done  out  1  check byte captured
 low_pkt_valid  out  1  pkt_valid fell during ld_state
 err  out  1  check mismatch, sticky per packet
 len_err  out  1  payload count differs from header length, sticky per packet
 data_out  out  DATA_W  byte to FIFO

Function
REQ-005 Header register SHALL load data_in when detect_addr && pkt_valid && data_in[1:0] != 2'b11; otherwise hold.
REQ-006 data_out SHALL update one cycle after qualifying inputs: lfd_state -> header register; ld_state && !fifo_full -> data_in; laf_state -> hold register; otherwise hold value.
REQ-007 Hold register SHALL load data_in when ld_state && fifo_full; precedence lfd_state > ld_state > laf_state if several asserted.
REQ-008 Running check SHALL clear on detect_addr; fold in header at lfd_state; fold in data_in at ld_state && pkt_valid && !full_state (XOR or add per CHK_MODE, result truncated to DATA_W).
REQ-009 Payload counter (LEN_W+1 bits, saturating) SHALL clear on detect_addr and increment under REQ-008 payload fold condition.
REQ-010 Packet check byte SHALL capture data_in when (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_pkt_valid && !parity_done).
REQ-011 parity_done SHALL set with the REQ-010 capture, hold, clear on detect_addr.
REQ-012 low_pkt_valid SHALL set when ld_state && !pkt_valid, clear on rst_int_reg; rst_int_reg wins if simultaneous.
REQ-013 err SHALL assert the cycle after parity_done rises if packet check byte != running check; sticky until detect_addr.
REQ-014 len_err SHALL assert in the same cycle as err evaluation if payload counter != header length field; sticky until detect_addr.
REQ-015 detect_addr clearing SHALL take precedence over concurrent set of parity_done, err, len_err.
REQ-016 Check byte SHALL NOT be folded into running check or counter.

Reset
REQ-017 reset asserted SHALL immediately force data_out, header, hold, running check, counter, packet check byte to 0 and parity_done, low_pkt_valid, err, len_err to 0, regardless of clk.
REQ-018 reset mid-packet SHALL abandon the packet; next packet after deassertion SHALL process normally from detect_addr.

Verification
REQ-019 CHK_MODE=0: header 0x16 (len 5, addr 2), 5 random payloads, correct XOR byte -> parity_done=1, err=0, len_err=0; data_out sequence 0x16 then payloads.
REQ-020 Same packet, check byte 0x2E (incorrect) -> err=1 one cycle after parity_done, holds until next detect_addr, then 0.
REQ-021 fifo_full high during payload 3 then laf_state -> hold register byte appears on data_out; running check unchanged while full_state=1; err=0.
REQ-022 Header 0x16 with 4 payloads and correct check -> len_err=1, err=0.
REQ-023 CHK_MODE=1, DATA_W=8: header 0x0E, payloads 0xFF,0x02,0x10 -> expected check 0x1F accepted (err=0); 0x20 -> err=1.
REQ-024 reset pulse between payloads 2 and 3 -> all outputs 0 within the cycle; following clean packet passes with err=0, len_err=0.
